// File: rtl/stride_counter_pkg.sv
// Shared types for the programmable-stride counter: count direction,
// overflow policy and controller state.
package stride_counter_pkg;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    typedef enum logic {
        OVF_WRAP = 1'b0,
        OVF_SAT  = 1'b1
    } ovf_mode_e;

    typedef enum logic {
        ST_COUNT = 1'b0,
        ST_SAT   = 1'b1
    } state_e;

endpackage

// File: rtl/stride_next.sv
// Combinational next-value unit: one stride step up or down, with the
// carry/borrow resolved as either a wrap or a clamp to the range limit.
module stride_next
    import stride_counter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] cnt,
    input  logic [WIDTH-1:0] stride,
    input  dir_e             dir,
    input  ovf_mode_e        mode,
    output logic [WIDTH-1:0] next_val,
    output logic             wrapped,
    output logic             saturate
);

    logic [WIDTH:0] result;
    logic           ovf;

    always_comb begin
        result   = '0;
        ovf      = 1'b0;
        next_val = '0;
        wrapped  = 1'b0;
        saturate = 1'b0;

        // The extra top bit is the carry going up and the borrow going down.
        if (dir == DIR_UP) begin
            result = {1'b0, cnt} + {1'b0, stride};
        end else begin
            result = {1'b0, cnt} - {1'b0, stride};
        end
        ovf      = result[WIDTH];
        next_val = result[WIDTH-1:0];

        if (ovf) begin
            if (mode == OVF_SAT) begin
                next_val = (dir == DIR_UP) ? {WIDTH{1'b1}} : '0;
                saturate = 1'b1;
            end else begin
                wrapped  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stride_counter.sv
// Programmable-stride up/down counter with wrap or saturate overflow policy,
// parallel load and registered terminal-count / wrap pulses.
module stride_counter
    import stride_counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int RST_VAL  = 1,
    parameter int DEF_STEP = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic [WIDTH-1:0] load_step_i,
    input  logic             dir_i,
    input  logic             sat_mode_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             tc_o,
    output logic             wrap_o,
    output logic             sat_o
);

    localparam logic [WIDTH-1:0] RST_CNT  = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0] RST_STEP = WIDTH'(DEF_STEP);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] stride_q, stride_d;
    state_e           state_q, state_d;
    logic             tc_q, tc_d;
    logic             wrap_q, wrap_d;

    logic [WIDTH-1:0] step_val;
    logic             step_wrapped;
    logic             step_saturate;

    stride_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .cnt      (cnt_q),
        .stride   (stride_q),
        .dir      (dir_e'(dir_i)),
        .mode     (ovf_mode_e'(sat_mode_i)),
        .next_val (step_val),
        .wrapped  (step_wrapped),
        .saturate (step_saturate)
    );

    always_comb begin
        cnt_d    = cnt_q;
        stride_d = stride_q;
        state_d  = state_q;
        tc_d     = 1'b0;
        wrap_d   = 1'b0;

        if (load_i) begin
            cnt_d    = load_val_i;
            stride_d = load_step_i;
            state_d  = ST_COUNT;
        end else if (en_i && (state_q == ST_COUNT) && (stride_q != '0)) begin
            // tc compares the landed value, so a clamp onto limit_i still fires it.
            cnt_d  = step_val;
            wrap_d = step_wrapped;
            tc_d   = (step_val == limit_i);
            if (step_saturate) begin
                state_d = ST_SAT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= RST_CNT;
            stride_q <= RST_STEP;
            state_q  <= ST_COUNT;
            tc_q     <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stride_q <= stride_d;
            state_q  <= state_d;
            tc_q     <= tc_d;
            wrap_q   <= wrap_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign tc_o   = tc_q;
    assign wrap_o = wrap_q;
    assign sat_o  = (state_q == ST_SAT);

endmodule

// File: tb/tb_stride_counter.sv
// Directed bench for stride_counter: a table of single-cycle vectors plus a
// full up-count wrap sequence.
module tb_stride_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en_i = 1'b0;
    logic       load_i = 1'b0;
    logic [7:0] load_val_i = '0;
    logic [7:0] load_step_i = '0;
    logic       dir_i = 1'b0;
    logic       sat_mode_i = 1'b0;
    logic [7:0] limit_i = '0;
    logic [7:0] cnt_o;
    logic       tc_o;
    logic       wrap_o;
    logic       sat_o;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       rst;
        logic       ld;
        logic [7:0] lv;
        logic [7:0] ls;
        logic       en;
        logic       dir;
        logic       sat;
        logic [7:0] lim;
        logic [7:0] e_cnt;
        logic       e_tc;
        logic       e_wrap;
        logic       e_sat;
    } vec_t;

    vec_t vecs[$];

    stride_counter dut (
        .clk         (clk),
        .reset       (reset),
        .en_i        (en_i),
        .load_i      (load_i),
        .load_val_i  (load_val_i),
        .load_step_i (load_step_i),
        .dir_i       (dir_i),
        .sat_mode_i  (sat_mode_i),
        .limit_i     (limit_i),
        .cnt_o       (cnt_o),
        .tc_o        (tc_o),
        .wrap_o      (wrap_o),
        .sat_o       (sat_o)
    );

    always #5 clk = ~clk;

    task automatic add(input logic rst, input logic ld, input logic [7:0] lv,
                       input logic [7:0] ls, input logic en, input logic dir,
                       input logic sat, input logic [7:0] lim, input logic [7:0] e_cnt,
                       input logic e_tc, input logic e_wrap, input logic e_sat);
        vec_t v;
        v.rst = rst; v.ld = ld; v.lv = lv; v.ls = ls; v.en = en; v.dir = dir;
        v.sat = sat; v.lim = lim; v.e_cnt = e_cnt; v.e_tc = e_tc;
        v.e_wrap = e_wrap; v.e_sat = e_sat;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [7:0] act,
                         input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=%0d required=%0d", name, idx, act, exp);
        end
    endtask

    task automatic apply_and_check(input string tag, input int idx, input vec_t v);
        @(negedge clk);
        reset = v.rst; load_i = v.ld; load_val_i = v.lv; load_step_i = v.ls;
        en_i = v.en; dir_i = v.dir; sat_mode_i = v.sat; limit_i = v.lim;
        @(posedge clk);
        #1;
        $display("%s step=%0d rst=%0b ld=%0b en=%0b dir=%0b sat_mode=%0b lim=%0d -> cnt=%0d tc=%0b wrap=%0b sat=%0b",
                 tag, idx, v.rst, v.ld, v.en, v.dir, v.sat, v.lim, cnt_o, tc_o, wrap_o, sat_o);
        check({tag, "_cnt"},  idx, cnt_o, v.e_cnt);
        check({tag, "_tc"},   idx, {7'd0, tc_o},   {7'd0, v.e_tc});
        check({tag, "_wrap"}, idx, {7'd0, wrap_o}, {7'd0, v.e_wrap});
        check({tag, "_sat"},  idx, {7'd0, sat_o},  {7'd0, v.e_sat});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t w;
        //   rst ld  lv    ls  en dir sat lim   cnt  tc wr st
        add(1, 0, 8'd0,  8'd0, 0, 0, 0, 8'd9,  8'd1,   0, 0, 0);
        add(0, 0, 8'd0,  8'd0, 1, 0, 0, 8'd9,  8'd3,   0, 0, 0);
        add(0, 0, 8'd0,  8'd0, 1, 0, 0, 8'd9,  8'd5,   0, 0, 0);
        add(0, 0, 8'd0,  8'd0, 1, 0, 0, 8'd9,  8'd7,   0, 0, 0);
        add(0, 0, 8'd0,  8'd0, 1, 0, 0, 8'd9,  8'd9,   1, 0, 0);
        add(0, 0, 8'd0,  8'd0, 1, 0, 0, 8'd9,  8'd11,  0, 0, 0);
        for (int i = 0; i < 5; i++)
            add(0, 0, 8'd0, 8'd0, 0, 0, 0, 8'd11, 8'd11, 0, 0, 0);
        // saturate up, then SAT ignores en/dir/mode until a load
        add(0, 1, 8'd250, 8'd4, 1, 0, 1, 8'd9, 8'd250,  0, 0, 0);
        add(0, 0, 8'd0,  8'd0, 1, 0, 1, 8'd9,  8'd254,  0, 0, 0);
        add(0, 0, 8'd0,  8'd0, 1, 0, 1, 8'd9,  8'd255,  0, 0, 1);
        add(0, 0, 8'd0,  8'd0, 1, 1, 1, 8'd9,  8'd255,  0, 0, 1);
        add(0, 0, 8'd0,  8'd0, 1, 0, 0, 8'd255, 8'd255, 0, 0, 1);
        add(0, 1, 8'd0,  8'd2, 0, 0, 0, 8'd9,  8'd0,    0, 0, 0);
        // down wrap, with tc and wrap together on 255
        add(0, 1, 8'd3,  8'd2, 0, 1, 0, 8'd255, 8'd3,   0, 0, 0);
        add(0, 0, 8'd0,  8'd0, 1, 1, 0, 8'd255, 8'd1,   0, 0, 0);
        add(0, 0, 8'd0,  8'd0, 1, 1, 0, 8'd255, 8'd255, 1, 1, 0);
        add(0, 0, 8'd0,  8'd0, 1, 1, 0, 8'd255, 8'd253, 0, 0, 0);
        // down saturate onto limit 0
        add(0, 1, 8'd3,  8'd2, 0, 1, 1, 8'd0,  8'd3,    0, 0, 0);
        add(0, 0, 8'd0,  8'd0, 1, 1, 1, 8'd0,  8'd1,    0, 0, 0);
        add(0, 0, 8'd0,  8'd0, 1, 1, 1, 8'd0,  8'd0,    1, 0, 1);
        add(0, 0, 8'd0,  8'd0, 1, 1, 1, 8'd0,  8'd0,    0, 0, 1);
        // load wins over en
        add(0, 1, 8'd40, 8'd2, 1, 0, 0, 8'd9,  8'd40,   0, 0, 0);
        // zero stride holds, no tc even on limit
        add(0, 1, 8'd40, 8'd0, 0, 0, 0, 8'd40, 8'd40,   0, 0, 0);
        add(0, 0, 8'd0,  8'd0, 1, 0, 0, 8'd40, 8'd40,   0, 0, 0);
        add(0, 0, 8'd0,  8'd0, 1, 1, 0, 8'd40, 8'd40,   0, 0, 0);
        // reset beats load and restores default stride
        add(1, 1, 8'd77, 8'd5, 1, 0, 0, 8'd9,  8'd1,    0, 0, 0);
        add(0, 0, 8'd0,  8'd0, 1, 0, 0, 8'd9,  8'd3,    0, 0, 0);
        add(0, 0, 8'd0,  8'd0, 1, 0, 0, 8'd9,  8'd5,    0, 0, 0);
        add(1, 0, 8'd0,  8'd0, 1, 0, 0, 8'd9,  8'd1,    0, 0, 0);

        foreach (vecs[i]) apply_and_check("vec", i, vecs[i]);

        // Full up count from reset with limit 8: odd values never land on it.
        w = '{rst: 1'b1, ld: 1'b0, lv: 8'd0, ls: 8'd0, en: 1'b0, dir: 1'b0,
              sat: 1'b0, lim: 8'd8, e_cnt: 8'd1, e_tc: 1'b0, e_wrap: 1'b0, e_sat: 1'b0};
        apply_and_check("wrapseq", 0, w);
        w.rst = 1'b0;
        w.en  = 1'b1;
        for (int k = 1; k <= 129; k++) begin
            w.e_cnt  = 8'((1 + 2 * k) % 256);
            w.e_wrap = (k == 128);
            apply_and_check("wrapseq", k, w);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
